// File: rtl/axi4l_mem_pkg.sv
// Shared constants, address-decode classes and LFSR helper for the AXI4-Lite memory slave.
package axi4l_mem_pkg;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    localparam logic [31:0] CON_ADDR    = 32'h1000_0000;
    localparam logic [31:0] PASS_ADDR   = 32'h2000_0000;
    localparam logic [31:0] PASS_MAGIC  = 32'd123456789;

    // Fibonacci taps x^16 + x^14 + x^13 + x^11, expressed as a right-shift feedback mask
    localparam logic [15:0] LFSR_SEED   = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS   = 16'h002D;

    typedef enum logic [1:0] {
        AK_MEM,
        AK_CON,
        AK_PASS,
        AK_ERR
    } addr_kind_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/axi4l_rd_fifo.sv
// Synchronous read-response queue; storage is not reset, only pointers and count.
module axi4l_rd_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/axi4l_mem_slave.sv
// AXI4-Lite simulation memory slave with console/pass-flag registers,
// queued reads with configurable latency and optional random ready backpressure.
module axi4l_mem_slave
    import axi4l_mem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MEM_BYTES  = 131072,
    parameter int RD_LAT     = 0,
    parameter int RD_DEPTH   = 4,
    parameter int RAND_STALL = 0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                awvalid,
    output logic                awready,
    input  logic [31:0]         awaddr,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic                bvalid,
    input  logic                bready,
    output logic [1:0]          bresp,
    input  logic                arvalid,
    output logic                arready,
    input  logic [31:0]         araddr,
    output logic                rvalid,
    input  logic                rready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                con_valid,
    output logic [7:0]          con_data,
    output logic                tests_passed
);

    localparam int STRB_W    = DATA_W / 8;
    localparam int BYTE_SH   = $clog2(STRB_W);
    localparam int MEM_WORDS = MEM_BYTES / STRB_W;
    localparam int IDX_W     = $clog2(MEM_WORDS);
    localparam int CNT_W     = $clog2(RD_DEPTH) + 1;
    localparam int LAT_W     = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

    logic [DATA_W-1:0] mem [MEM_WORDS];

    logic              r_aw_full;
    logic [31:0]       r_awaddr;
    logic              r_w_full;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic              r_bvalid;
    logic [1:0]        r_bresp;
    logic              r_con_valid;
    logic [7:0]        r_con_data;
    logic              r_tests_passed;
    logic [15:0]       r_lfsr;
    logic [LAT_W-1:0]  r_lat_cnt;

    logic              w_stall_ar;
    logic              w_stall_aw;
    logic              w_stall_w;
    logic              w_commit;
    addr_kind_e        w_wr_kind;
    addr_kind_e        w_rd_kind;
    logic [IDX_W-1:0]  w_widx;
    logic [IDX_W-1:0]  w_ridx;
    logic [DATA_W+1:0] w_push_data;
    logic [DATA_W+1:0] w_head;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic              w_unused_full;
    logic [CNT_W-1:0]  w_count;

    function automatic addr_kind_e decode(input logic [31:0] a);
        if (a == CON_ADDR)               return AK_CON;
        else if (a == PASS_ADDR)         return AK_PASS;
        else if (a >= 32'(MEM_BYTES))    return AK_ERR;
        else                             return AK_MEM;
    endfunction

    assign w_stall_ar = (RAND_STALL != 0) && r_lfsr[0];
    assign w_stall_aw = (RAND_STALL != 0) && r_lfsr[1];
    assign w_stall_w  = (RAND_STALL != 0) && r_lfsr[2];

    assign awready = resetn && !r_aw_full && !w_stall_aw;
    assign wready  = resetn && !r_w_full && !w_stall_w;
    assign arready = resetn && (w_count < CNT_W'(RD_DEPTH)) && !w_stall_ar;

    assign w_wr_kind = decode(r_awaddr);
    assign w_rd_kind = decode(araddr);
    assign w_widx    = r_awaddr[IDX_W+BYTE_SH-1:BYTE_SH];
    assign w_ridx    = araddr[IDX_W+BYTE_SH-1:BYTE_SH];
    assign w_commit  = r_aw_full && r_w_full && !r_bvalid;

    assign bvalid       = r_bvalid;
    assign bresp        = r_bresp;
    assign con_valid    = r_con_valid;
    assign con_data     = r_con_data;
    assign tests_passed = r_tests_passed;

    // Memory is intentionally outside reset so contents survive a mid-run reset
    always_ff @(posedge clk) begin
        if (resetn && w_commit && (w_wr_kind == AK_MEM)) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (r_wstrb[b]) begin
                    mem[w_widx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_aw_full      <= 1'b0;
            r_awaddr       <= '0;
            r_w_full       <= 1'b0;
            r_wdata        <= '0;
            r_wstrb        <= '0;
            r_bvalid       <= 1'b0;
            r_bresp        <= RESP_OKAY;
            r_con_valid    <= 1'b0;
            r_con_data     <= '0;
            r_tests_passed <= 1'b0;
            r_lfsr         <= LFSR_SEED;
        end else begin
            r_con_valid <= 1'b0;
            if (RAND_STALL != 0) begin
                r_lfsr <= lfsr_next(r_lfsr);
            end
            if (awvalid && awready) begin
                r_aw_full <= 1'b1;
                r_awaddr  <= awaddr;
            end
            if (wvalid && wready) begin
                r_w_full <= 1'b1;
                r_wdata  <= wdata;
                r_wstrb  <= wstrb;
            end
            // Commit needs both holds full, so it never overlaps a hold load
            if (w_commit) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= (w_wr_kind == AK_ERR) ? RESP_SLVERR : RESP_OKAY;
                if (w_wr_kind == AK_CON) begin
                    r_con_valid <= 1'b1;
                    r_con_data  <= r_wdata[7:0];
                end
                if ((w_wr_kind == AK_PASS) && (r_wdata[31:0] == PASS_MAGIC)) begin
                    r_tests_passed <= 1'b1;
                end
            end else if (r_bvalid && bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_push_data = {RESP_OKAY, {DATA_W{1'b0}}};
        case (w_rd_kind)
            AK_MEM:  w_push_data = {RESP_OKAY, mem[w_ridx]};
            AK_ERR:  w_push_data = {RESP_SLVERR, {DATA_W{1'b0}}};
            default: w_push_data = {RESP_OKAY, {DATA_W{1'b0}}};
        endcase
    end

    assign w_push = arvalid && arready;
    assign w_pop  = rvalid && rready;

    axi4l_rd_fifo #(
        .WIDTH (DATA_W + 2),
        .DEPTH (RD_DEPTH)
    ) u_rd_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_din   (w_push_data),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_unused_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Counts cycles the current head has been waiting; restarts for each new head
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_lat_cnt <= '0;
        end else if (w_pop) begin
            r_lat_cnt <= '0;
        end else if (!w_empty && (r_lat_cnt != LAT_W'(RD_LAT))) begin
            r_lat_cnt <= r_lat_cnt + LAT_W'(1);
        end
    end

    assign rvalid = !w_empty && (r_lat_cnt == LAT_W'(RD_LAT));
    assign rdata  = rvalid ? w_head[DATA_W-1:0] : '0;
    assign rresp  = rvalid ? w_head[DATA_W+1:DATA_W] : RESP_OKAY;

endmodule

// File: tb/tb_axi4l_mem_slave.sv
// Directed bench: instance 0 uses default parameters, instance 1 runs with
// read latency 3 and random backpressure for the scoreboard/reset scenario.
module tb_axi4l_mem_slave;
    import axi4l_mem_pkg::*;

    localparam int TMO = 100;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic        awvalid[2], awready[2], wvalid[2], wready[2], bvalid[2], bready[2];
    logic        arvalid[2], arready[2], rvalid[2], rready[2], con_valid[2], tests_passed[2];
    logic [31:0] awaddr[2], wdata[2], araddr[2], rdata[2];
    logic [3:0]  wstrb[2];
    logic [1:0]  bresp[2], rresp[2];
    logic [7:0]  con_data[2];

    int errors = 0;
    int checks = 0;

    axi4l_mem_slave dut0 (
        .clk(clk), .resetn(resetn),
        .awvalid(awvalid[0]), .awready(awready[0]), .awaddr(awaddr[0]),
        .wvalid(wvalid[0]), .wready(wready[0]), .wdata(wdata[0]), .wstrb(wstrb[0]),
        .bvalid(bvalid[0]), .bready(bready[0]), .bresp(bresp[0]),
        .arvalid(arvalid[0]), .arready(arready[0]), .araddr(araddr[0]),
        .rvalid(rvalid[0]), .rready(rready[0]), .rdata(rdata[0]), .rresp(rresp[0]),
        .con_valid(con_valid[0]), .con_data(con_data[0]), .tests_passed(tests_passed[0])
    );

    axi4l_mem_slave #(
        .DATA_W(32), .MEM_BYTES(4096), .RD_LAT(3), .RD_DEPTH(4), .RAND_STALL(1)
    ) dut1 (
        .clk(clk), .resetn(resetn),
        .awvalid(awvalid[1]), .awready(awready[1]), .awaddr(awaddr[1]),
        .wvalid(wvalid[1]), .wready(wready[1]), .wdata(wdata[1]), .wstrb(wstrb[1]),
        .bvalid(bvalid[1]), .bready(bready[1]), .bresp(bresp[1]),
        .arvalid(arvalid[1]), .arready(arready[1]), .araddr(araddr[1]),
        .rvalid(rvalid[1]), .rready(rready[1]), .rdata(rdata[1]), .rresp(rresp[1]),
        .con_valid(con_valid[1]), .con_data(con_data[1]), .tests_passed(tests_passed[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d);
        awvalid[d] = 1'b0; awaddr[d] = '0;
        wvalid[d]  = 1'b0; wdata[d]  = '0; wstrb[d] = '0;
        bready[d]  = 1'b0;
        arvalid[d] = 1'b0; araddr[d] = '0;
        rready[d]  = 1'b0;
    endtask

    task automatic send_aw(input int d, input logic [31:0] a);
        int n = 0;
        awvalid[d] = 1'b1;
        awaddr[d]  = a;
        while (!awready[d] && n < TMO) begin tick; n++; end
        chk("aw_handshake", awready[d], 1'b1);
        tick;
        awvalid[d] = 1'b0;
    endtask

    task automatic send_w(input int d, input logic [31:0] dat, input logic [3:0] s);
        int n = 0;
        wvalid[d] = 1'b1;
        wdata[d]  = dat;
        wstrb[d]  = s;
        while (!wready[d] && n < TMO) begin tick; n++; end
        chk("w_handshake", wready[d], 1'b1);
        tick;
        wvalid[d] = 1'b0;
    endtask

    task automatic wait_b(input int d, output logic [1:0] resp, output logic cv, output logic [7:0] cd);
        int n = 0;
        bready[d] = 1'b1;
        while (!bvalid[d] && n < TMO) begin tick; n++; end
        chk("b_valid", bvalid[d], 1'b1);
        resp = bresp[d];
        cv   = con_valid[d];
        cd   = con_data[d];
        tick;
        bready[d] = 1'b0;
    endtask

    task automatic wr(input int d, input logic [31:0] a, input logic [31:0] dat, input logic [3:0] s,
                      output logic [1:0] resp, output logic cv, output logic [7:0] cd);
        send_aw(d, a);
        send_w(d, dat, s);
        wait_b(d, resp, cv, cd);
    endtask

    task automatic rd(input int d, input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        arvalid[d] = 1'b1;
        araddr[d]  = a;
        while (!arready[d] && n < TMO) begin tick; n++; end
        chk("ar_handshake", arready[d], 1'b1);
        tick;
        arvalid[d] = 1'b0;
        rready[d]  = 1'b1;
        n = 0;
        while (!rvalid[d] && n < TMO) begin tick; n++; end
        chk("r_valid", rvalid[d], 1'b1);
        data = rdata[d];
        resp = rresp[d];
        tick;
        rready[d] = 1'b0;
    endtask

    logic [1:0]  resp;
    logic        cv;
    logic [7:0]  cd;
    logic [31:0] rd_d;
    logic [1:0]  rd_r;
    logic [31:0] sb [16];
    logic [31:0] dat;
    logic [3:0]  strb;
    int          idx;

    initial begin
        idle(0);
        idle(1);

        // Reset values
        resetn = 1'b0;
        repeat (3) tick;
        chk("rst_awready", awready[0], 1'b0);
        chk("rst_wready", wready[0], 1'b0);
        chk("rst_arready", arready[0], 1'b0);
        chk("rst_bvalid", bvalid[0], 1'b0);
        chk("rst_rvalid", rvalid[0], 1'b0);
        chk("rst_tests_passed", tests_passed[0], 1'b0);
        chk("rst_con", {con_valid[0], con_data[0]}, 9'h0);
        resetn = 1'b1;
        tick;
        chk("post_rst_readies", {awready[0], wready[0], arready[0]}, 3'b111);

        // Zero-latency read timing
        wr(0, 32'h10, 32'hDEAD_BEEF, 4'hF, resp, cv, cd);
        chk("wr10_bresp", resp, RESP_OKAY);
        chk("wr10_no_con", cv, 1'b0);
        rready[0]  = 1'b1;
        arvalid[0] = 1'b1;
        araddr[0]  = 32'h10;
        chk("rd10_arready", arready[0], 1'b1);
        tick;
        arvalid[0] = 1'b0;
        chk("rd10_rvalid_next_cycle", rvalid[0], 1'b1);
        chk("rd10_rdata", rdata[0], 32'hDEAD_BEEF);
        chk("rd10_rresp", rresp[0], RESP_OKAY);
        tick;
        chk("rd10_popped", rvalid[0], 1'b0);
        rready[0] = 1'b0;

        // W before AW with partial strobes
        wr(0, 32'h20, 32'h0, 4'hF, resp, cv, cd);
        wvalid[0] = 1'b1;
        wdata[0]  = 32'h1122_3344;
        wstrb[0]  = 4'b0101;
        chk("wfirst_wready", wready[0], 1'b1);
        tick;
        wvalid[0] = 1'b0;
        chk("wfirst_w_held", wready[0], 1'b0);
        tick;
        chk("wfirst_no_bvalid", bvalid[0], 1'b0);
        awvalid[0] = 1'b1;
        awaddr[0]  = 32'h20;
        chk("wfirst_awready", awready[0], 1'b1);
        tick;
        awvalid[0] = 1'b0;
        chk("wfirst_bvalid_pre_commit", bvalid[0], 1'b0);
        tick;
        chk("wfirst_bvalid", bvalid[0], 1'b1);
        tick;
        chk("wfirst_bvalid_stable_no_bready", bvalid[0], 1'b1);
        bready[0] = 1'b1;
        tick;
        bready[0] = 1'b0;
        chk("wfirst_bvalid_cleared", bvalid[0], 1'b0);
        rd(0, 32'h20, rd_d, rd_r);
        chk("wfirst_readback", rd_d, 32'h0022_0044);

        // Read FIFO full behaviour and ordering
        for (int i = 0; i < 5; i++) begin
            wr(0, 32'h100 + 32'(4*i), 32'hA000_0000 + 32'(i), 4'hF, resp, cv, cd);
        end
        rready[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            arvalid[0] = 1'b1;
            araddr[0]  = 32'h100 + 32'(4*i);
            chk("fill_arready", arready[0], 1'b1);
            tick;
        end
        araddr[0] = 32'h110;
        chk("full_arready", arready[0], 1'b0);
        tick;
        chk("full_arready_held", arready[0], 1'b0);
        chk("full_head_rdata", rdata[0], 32'hA000_0000);
        rready[0] = 1'b1;
        chk("full_no_pop_lookahead", arready[0], 1'b0);
        chk("pop0_rdata", rdata[0], 32'hA000_0000);
        tick;
        chk("pop1_rdata", rdata[0], 32'hA000_0001);
        chk("pop1_arready", arready[0], 1'b1);
        tick;
        arvalid[0] = 1'b0;
        chk("pop2_rdata", rdata[0], 32'hA000_0002);
        tick;
        chk("pop3_rdata", rdata[0], 32'hA000_0003);
        tick;
        chk("pop4_rvalid", rvalid[0], 1'b1);
        chk("pop4_rdata", rdata[0], 32'hA000_0004);
        tick;
        chk("fifo_drained", rvalid[0], 1'b0);
        rready[0] = 1'b0;

        // Console, pass flag and out-of-range accesses
        wr(0, CON_ADDR, 32'h0000_0141, 4'hF, resp, cv, cd);
        chk("con_pulse", cv, 1'b1);
        chk("con_data", cd, 8'h41);
        chk("con_bresp", resp, RESP_OKAY);
        chk("con_pulse_one_cycle", con_valid[0], 1'b0);
        wr(0, PASS_ADDR, 32'h1, 4'hF, resp, cv, cd);
        chk("bad_magic_no_pass", tests_passed[0], 1'b0);
        wr(0, PASS_ADDR, 32'd123456789, 4'hF, resp, cv, cd);
        chk("pass_bresp", resp, RESP_OKAY);
        chk("pass_set", tests_passed[0], 1'b1);
        wr(0, 32'h0, 32'h1234_5678, 4'hF, resp, cv, cd);
        wr(0, 32'h0004_0000, 32'h5555_5555, 4'hF, resp, cv, cd);
        chk("oob_wr_slverr", resp, RESP_SLVERR);
        chk("pass_sticky", tests_passed[0], 1'b1);
        rd(0, 32'h0, rd_d, rd_r);
        chk("oob_wr_mem_unchanged", rd_d, 32'h1234_5678);
        rd(0, 32'h0004_0000, rd_d, rd_r);
        chk("oob_rd_data", rd_d, 32'h0);
        chk("oob_rd_slverr", rd_r, RESP_SLVERR);
        rd(0, CON_ADDR, rd_d, rd_r);
        chk("con_rd", {rd_r, rd_d}, {RESP_OKAY, 32'h0});

        // Latency 3 with random backpressure against a scoreboard
        for (int i = 0; i < 16; i++) begin
            sb[i] = 32'hC0DE_0000 ^ (32'(i) * 32'h0101_0101);
            wr(1, 32'(4*i), sb[i], 4'hF, resp, cv, cd);
        end
        for (int k = 0; k < 200; k++) begin
            idx = int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                dat  = $urandom;
                strb = 4'($urandom_range(0, 15));
                wr(1, 32'(4*idx), dat, strb, resp, cv, cd);
                chk("rand_bresp", resp, RESP_OKAY);
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) sb[idx][8*b +: 8] = dat[8*b +: 8];
                end
            end else begin
                rd(1, 32'(4*idx), rd_d, rd_r);
                chk("rand_rdata", rd_d, sb[idx]);
                chk("rand_rresp", rd_r, RESP_OKAY);
            end
        end

        // Reset with reads queued and an address held but no data
        rready[1]  = 1'b0;
        arvalid[1] = 1'b1;
        awvalid[1] = 1'b1;
        awaddr[1]  = 32'h8;
        for (int i = 0; i < 6; i++) begin
            araddr[1] = 32'(4*i);
            tick;
        end
        resetn = 1'b0;
        tick;
        chk("midrst_outputs",
            {awready[1], wready[1], arready[1], bvalid[1], rvalid[1], bresp[1], rresp[1],
             rdata[1], con_valid[1], con_data[1], tests_passed[1]}, '0);
        chk("midrst_pass_cleared_dut0", tests_passed[0], 1'b0);
        idle(1);
        tick;
        resetn = 1'b1;
        tick;
        for (int i = 0; i < 16; i++) begin
            rd(1, 32'(4*i), rd_d, rd_r);
            chk("post_rst_mem", rd_d, sb[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
